// File: rtl/ddr3_mig_burst_writer.sv
// Write-traffic generator for one Spartan-6 MIG user port.
// Each burst fills the write FIFO with BURST_LEN pattern words and then
// issues one write command. The address wraps inside
// [BASE_ADDR, ADDR_LIMIT). The run stops after NUM_BURSTS commands, or
// runs until prepareFin drops when NUM_BURSTS is 0.
module ddr3_mig_burst_writer #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    BURST_LEN  = 4,
    parameter int                    ADDR_WIDTH = 30,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 30'h0000_1000,
    parameter int                    NUM_BURSTS = 0
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  prepareFin,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  c3_p0_cmd_en,
    output logic [2:0]            c3_p0_cmd_instr,
    output logic [5:0]            c3_p0_cmd_bl,
    output logic [ADDR_WIDTH-1:0] c3_p0_cmd_byte_addr,
    input  logic                  c3_p0_cmd_full,
    output logic                  c3_p0_wr_en,
    output logic [DATA_WIDTH-1:0] c3_p0_wr_data,
    input  logic                  c3_p0_wr_full,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           burst_cnt
);
    localparam int WBYTES = DATA_WIDTH / 8;
    localparam int STRIDE = BURST_LEN * WBYTES;

    // Reject bad geometry at elaboration time.
    if (BURST_LEN < 1 || BURST_LEN > 64) begin : g_bl_chk
        $error("BURST_LEN must be in 1..64");
    end
    if (((longint'(ADDR_LIMIT) - longint'(BASE_ADDR)) % STRIDE) != 0) begin : g_win_chk
        $error("STRIDE must divide ADDR_LIMIT-BASE_ADDR");
    end

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, DONE} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              mode_q;
    logic [DATA_WIDTH-1:0]   seed_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_inc;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [6:0]              word_cnt;
    logic [31:0]             bcnt_q;
    logic                    last_word;
    logic                    start_ok;

    // First word of a run for the selected pattern.
    function automatic logic [DATA_WIDTH-1:0] first_word(
        input logic [1:0] m, input logic [DATA_WIDTH-1:0] s);
        case (m)
            2'b10:   first_word = DATA_WIDTH'(1);
            2'b11:   first_word = DATA_WIDTH'(BASE_ADDR);
            default: first_word = s;
        endcase
    endfunction

    // Word following 'cur' inside a burst. Address mode across a burst
    // boundary is fixed up at command accept, where the wrapped address is known.
    function automatic logic [DATA_WIDTH-1:0] next_word(
        input logic [1:0] m, input logic [DATA_WIDTH-1:0] s,
        input logic [DATA_WIDTH-1:0] cur);
        case (m)
            2'b00:   next_word = cur + DATA_WIDTH'(1);
            2'b01:   next_word = s;
            2'b10:   next_word = {cur[DATA_WIDTH-2:0], cur[DATA_WIDTH-1]};
            default: next_word = cur + DATA_WIDTH'(WBYTES);
        endcase
    endfunction

    assign start_ok  = start && prepareFin && (state == IDLE || state == DONE);
    assign last_word = (word_cnt == 7'(BURST_LEN - 1));
    assign addr_inc  = addr_q + ADDR_WIDTH'(STRIDE);
    assign addr_nxt  = (addr_inc >= ADDR_LIMIT) ? BASE_ADDR : addr_inc;

    assign c3_p0_cmd_instr     = 3'b000;
    assign c3_p0_cmd_bl        = 6'(BURST_LEN - 1);
    assign c3_p0_cmd_byte_addr = addr_q;
    assign c3_p0_wr_data       = data_q;
    assign burst_cnt           = bcnt_q;
    assign busy                = (state == FILL) || (state == ISSUE);
    assign done                = (state == DONE);

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and FIFO strobes. Calibration loss gates both strobes at once.
    always_comb begin
        state_nxt    = state;
        c3_p0_wr_en  = 1'b0;
        c3_p0_cmd_en = 1'b0;
        if (!prepareFin) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start_ok) state_nxt = FILL;
                FILL: begin
                    c3_p0_wr_en = !c3_p0_wr_full;
                    if (c3_p0_wr_en && last_word) state_nxt = ISSUE;
                end
                ISSUE: begin
                    c3_p0_cmd_en = !c3_p0_cmd_full;
                    if (c3_p0_cmd_en) begin
                        if (NUM_BURSTS != 0 && (bcnt_q + 32'd1) == 32'(NUM_BURSTS))
                            state_nxt = DONE;
                        else
                            state_nxt = FILL;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: pattern word, burst address, word and burst counters.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 2'b00;
            seed_q   <= '0;
            data_q   <= '0;
            addr_q   <= BASE_ADDR;
            word_cnt <= '0;
            bcnt_q   <= '0;
        end else if (!prepareFin) begin
            mode_q   <= 2'b00;
            seed_q   <= '0;
            data_q   <= '0;
            addr_q   <= BASE_ADDR;
            word_cnt <= '0;
            bcnt_q   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        mode_q   <= mode;
                        seed_q   <= seed;
                        data_q   <= first_word(mode, seed);
                        addr_q   <= BASE_ADDR;
                        word_cnt <= '0;
                        bcnt_q   <= '0;
                    end
                end
                FILL: begin
                    if (c3_p0_wr_en) begin
                        data_q   <= next_word(mode_q, seed_q, data_q);
                        word_cnt <= word_cnt + 7'd1;
                    end
                end
                ISSUE: begin
                    if (c3_p0_cmd_en) begin
                        addr_q   <= addr_nxt;
                        bcnt_q   <= bcnt_q + 32'd1;
                        word_cnt <= '0;
                        if (mode_q == 2'b11) data_q <= DATA_WIDTH'(addr_nxt);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/ddr3_mig_burst_writer.md
Name: ddr3_mig_burst_writer

Overview:
Parametrised write-traffic generator for one Spartan-6 MIG user port (c3_p0). After calibration (prepareFin) and a start pulse, it fills the port write FIFO with BURST_LEN words in a selectable pattern, then issues one write command per burst. It honours wr_full/cmd_full back-pressure, wraps the address inside a window and stops after a programmable burst count. It sits between test/bring-up logic and the MIG and can be used alongside a matching read checker.

Parameters:
DATA_WIDTH, 64, port data width in bits (32/64/128)
BURST_LEN, 4, words per command, 1..64
ADDR_WIDTH, 30, MIG byte-address width
BASE_ADDR, 0, first byte address; wrap target
ADDR_LIMIT, 30'h0000_1000, exclusive upper bound of the address window
NUM_BURSTS, 0, bursts per run; 0 = continuous until prepareFin drops

Ports:
clock  in  1  user-port clock
rst_n  in  1  asynchronous active-low reset
prepareFin  in  1  MIG calibration done; low aborts any run
start  in  1  one-cycle run request; ignored while busy or prepareFin=0
mode  in  2  pattern: 00 incr, 01 constant, 10 walking-one, 11 address-as-data; sampled on start
seed  in  DATA_WIDTH  first word (incr) / constant value; sampled on start
c3_p0_cmd_en  out  1  command strobe
c3_p0_cmd_instr  out  3  fixed 3'b000 (write)
c3_p0_cmd_bl  out  6  BURST_LEN-1
c3_p0_cmd_byte_addr  out  ADDR_WIDTH  burst start byte address
c3_p0_cmd_full  in  1  command FIFO full
c3_p0_wr_en  out  1  write-data strobe
c3_p0_wr_data  out  DATA_WIDTH  write word
c3_p0_wr_full  in  1  write FIFO full
busy  out  1  run in progress
done  out  1  run completed (NUM_BURSTS>0 only)
burst_cnt  out  32  commands accepted this run

Behaviour:
- Reset: state IDLE; cmd_byte_addr=BASE_ADDR; wr_data=0; burst_cnt=0; cmd_en, wr_en, busy, done=0. cmd_instr and cmd_bl are constants.
- States: IDLE, FILL, ISSUE, DONE.
- IDLE: start & prepareFin -> FILL; latch mode/seed; set cmd_byte_addr=BASE_ADDR; word_cnt=0; burst_cnt=0; done=0; wr_data=first pattern word.
- FILL: wr_en = !wr_full (combinational). A word is accepted on each cycle with wr_en=1; wr_data advances to the next pattern word that cycle and word_cnt increments. The cycle with the BURST_LEN-th accept -> ISSUE. While wr_full=1, wr_en=0 and wr_data holds.
- ISSUE: cmd_en = !cmd_full (combinational); cmd_byte_addr is stable. On accept: burst_cnt+1; addr += STRIDE, where STRIDE = BURST_LEN*DATA_WIDTH/8. If addr+STRIDE >= ADDR_LIMIT, addr = BASE_ADDR. Then if NUM_BURSTS!=0 and the new burst_cnt==NUM_BURSTS -> DONE, else -> FILL with word_cnt=0.
- DONE: done=1, busy=0. start & prepareFin restarts the run exactly as from IDLE.
- busy=1 in FILL and ISSUE.
- Patterns:
  - incr: seed, seed+1, ..., mod 2^DATA_WIDTH; continues across bursts.
  - constant: seed every word.
  - walking-one: 1, then rotate left by 1 per word; the MSB wraps to bit 0.
  - address-as-data: zero-extended byte address of the word = burst addr + k*DATA_WIDTH/8.
- wr_en and cmd_en are never high in the same cycle. The write data for a burst is fully written before its command is issued.
- prepareFin low in any state: next cycle -> IDLE, with the same register values as reset. cmd_en and wr_en drop combinationally in that same cycle. Partial FIFO contents are the integrator's responsibility.
- Async rst_n mid-run: immediate return to reset values.
- Assertion: BURST_LEN in 1..64; STRIDE divides ADDR_LIMIT-BASE_ADDR.

Test Plan:
1. Defaults, mode=00, seed=0, no back-pressure, NUM_BURSTS=3 -> data 0..11; three commands with addr 0, 0x20, 0x40; each cmd_en one cycle after the 4th wr_en; done=1; burst_cnt=3.
2. wr_full held high for 5 cycles mid-burst -> wr_en low for those cycles; no word lost or duplicated; data sequence unbroken.
3. cmd_full high for 3 cycles in ISSUE -> cmd_en low for 3 cycles, then a single one-cycle pulse; addr advances once.
4. ADDR_LIMIT=0x40, continuous run -> addresses 0, 0x20, 0, 0x20 ...; burst_cnt increments freely.
5. mode=10, DATA_WIDTH=64 -> words 1, 2, 4, 8, ...; word 65 = 1. mode=11 -> words equal their byte addresses 0, 8, 0x10, 0x18.
6. prepareFin dropped during FILL -> wr_en=0 the same cycle; IDLE next cycle; busy=0; start afterwards ignored until prepareFin returns high.
